// File: rtl/fight_referee.sv
`default_nettype none
// ============================================================================
// Module      : fight_referee
// Description : Round controller and hit arbiter for the two-player fight.
//               Sequences menu/countdown/fight/game-over, resolves attacks,
//               tracks health and the round timer.
// Revision    : 1.0 - initial release
// ============================================================================
module fight_referee #(
    parameter int MAX_HEALTH        = 5,
    parameter int HIT_RANGE         = 4,
    parameter int TICKS_PER_SEC     = 60,
    parameter int ROUND_SECONDS     = 60,
    parameter int COUNTDOWN_SECONDS = 3
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic [2:0] i_p1_state,
    input  logic [2:0] i_p2_state,
    input  logic [4:0] i_p1_pos,
    input  logic [4:0] i_p2_pos,
    output logic [1:0] o_phase,
    output logic       o_freeze,
    output logic [2:0] o_p1_health,
    output logic [2:0] o_p2_health,
    output logic [6:0] o_timer,
    output logic [1:0] o_countdown,
    output logic       o_hit_p1,
    output logic       o_hit_p2,
    output logic [1:0] o_winner,
    output logic       o_game_over
);

    localparam logic [1:0] c_MENU      = 2'b00;
    localparam logic [1:0] c_COUNTDOWN = 2'b01;
    localparam logic [1:0] c_FIGHT     = 2'b10;
    localparam logic [1:0] c_GAME_OVER = 2'b11;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_P1   = 2'b01;
    localparam logic [1:0] c_WIN_P2   = 2'b10;
    localparam logic [1:0] c_WIN_DRAW = 2'b11;

    localparam int               c_SUB_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_SUB_W-1:0] c_SUB_LAST = c_SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [2:0]       c_MAX_HEALTH = 3'(MAX_HEALTH);
    localparam logic [4:0]       c_HIT_RANGE  = 5'(HIT_RANGE);
    localparam logic [6:0]       c_ROUND      = 7'(ROUND_SECONDS);
    localparam logic [1:0]       c_COUNT      = 2'(COUNTDOWN_SECONDS);

    logic [1:0]         r_phase;
    logic [2:0]         r_p1_health;
    logic [2:0]         r_p2_health;
    logic [6:0]         r_timer;
    logic [1:0]         r_countdown;
    logic [c_SUB_W-1:0] r_sub;
    logic [2:0]         r_p1_prev;
    logic [2:0]         r_p2_prev;
    logic               r_hit_p1;
    logic               r_hit_p2;
    logic [1:0]         r_winner;

    logic [4:0] w_dist;
    logic       w_in_range;
    logic       w_p1_onset;
    logic       w_p2_onset;
    logic [2:0] w_dmg_to_p1;
    logic [2:0] w_dmg_to_p2;
    logic [2:0] w_p1_health_nxt;
    logic [2:0] w_p2_health_nxt;
    logic       w_sub_wrap;
    logic [6:0] w_timer_nxt;
    logic       w_round_end;
    logic [1:0] w_winner_nxt;

    function automatic logic is_attack(input logic [2:0] state);
        return (state == 3'b011) || (state == 3'b100);
    endfunction

    // A defender stepping backward absorbs one point of damage.
    function automatic logic [2:0] attack_damage(input logic [2:0] att, input logic [2:0] def);
        logic [2:0] dmg;
        dmg = (att == 3'b100) ? 3'd2 : 3'd1;
        if (def == 3'b001) begin
            dmg = dmg - 3'd1;
        end
        return dmg;
    endfunction

    always_comb begin
        w_dist          = (i_p1_pos >= i_p2_pos) ? (i_p1_pos - i_p2_pos) : (i_p2_pos - i_p1_pos);
        w_in_range      = (w_dist <= c_HIT_RANGE);
        w_p1_onset      = is_attack(i_p1_state) && !is_attack(r_p1_prev);
        w_p2_onset      = is_attack(i_p2_state) && !is_attack(r_p2_prev);
        w_dmg_to_p2     = (w_p1_onset && w_in_range) ? attack_damage(i_p1_state, i_p2_state) : 3'd0;
        w_dmg_to_p1     = (w_p2_onset && w_in_range) ? attack_damage(i_p2_state, i_p1_state) : 3'd0;
        w_p1_health_nxt = (r_p1_health > w_dmg_to_p1) ? (r_p1_health - w_dmg_to_p1) : 3'd0;
        w_p2_health_nxt = (r_p2_health > w_dmg_to_p2) ? (r_p2_health - w_dmg_to_p2) : 3'd0;
        w_sub_wrap      = (r_sub == c_SUB_LAST);
        w_timer_nxt     = (w_sub_wrap && (r_timer != 7'd0)) ? (r_timer - 7'd1) : r_timer;

        // Damage lands before the timer-expiry verdict on the same tick.
        w_round_end  = 1'b0;
        w_winner_nxt = c_WIN_NONE;
        if ((w_p1_health_nxt == 3'd0) || (w_p2_health_nxt == 3'd0)) begin
            w_round_end = 1'b1;
            if ((w_p1_health_nxt == 3'd0) && (w_p2_health_nxt == 3'd0)) begin
                w_winner_nxt = c_WIN_DRAW;
            end else if (w_p1_health_nxt == 3'd0) begin
                w_winner_nxt = c_WIN_P2;
            end else begin
                w_winner_nxt = c_WIN_P1;
            end
        end else if (w_timer_nxt == 7'd0) begin
            w_round_end = 1'b1;
            if (w_p1_health_nxt > w_p2_health_nxt) begin
                w_winner_nxt = c_WIN_P1;
            end else if (w_p1_health_nxt < w_p2_health_nxt) begin
                w_winner_nxt = c_WIN_P2;
            end else begin
                w_winner_nxt = c_WIN_DRAW;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_phase     <= c_MENU;
            r_p1_health <= c_MAX_HEALTH;
            r_p2_health <= c_MAX_HEALTH;
            r_timer     <= c_ROUND;
            r_countdown <= 2'd0;
            r_sub       <= '0;
            r_p1_prev   <= 3'd0;
            r_p2_prev   <= 3'd0;
            r_hit_p1    <= 1'b0;
            r_hit_p2    <= 1'b0;
            r_winner    <= c_WIN_NONE;
        end else begin
            r_hit_p1 <= 1'b0;
            r_hit_p2 <= 1'b0;
            case (r_phase)
                c_MENU: begin
                    if (i_start) begin
                        r_phase     <= c_COUNTDOWN;
                        r_p1_health <= c_MAX_HEALTH;
                        r_p2_health <= c_MAX_HEALTH;
                        r_timer     <= c_ROUND;
                        r_winner    <= c_WIN_NONE;
                        r_countdown <= c_COUNT;
                        r_sub       <= '0;
                    end
                end
                c_COUNTDOWN: begin
                    if (i_tick) begin
                        if (w_sub_wrap) begin
                            r_sub       <= '0;
                            r_countdown <= r_countdown - 2'd1;
                            if (r_countdown == 2'd1) begin
                                r_phase   <= c_FIGHT;
                                r_p1_prev <= 3'd0;
                                r_p2_prev <= 3'd0;
                            end
                        end else begin
                            r_sub <= r_sub + 1'b1;
                        end
                    end
                end
                c_FIGHT: begin
                    if (i_tick) begin
                        r_p1_prev   <= i_p1_state;
                        r_p2_prev   <= i_p2_state;
                        r_sub       <= w_sub_wrap ? '0 : (r_sub + 1'b1);
                        r_timer     <= w_timer_nxt;
                        r_p1_health <= w_p1_health_nxt;
                        r_p2_health <= w_p2_health_nxt;
                        r_hit_p1    <= (w_dmg_to_p1 != 3'd0);
                        r_hit_p2    <= (w_dmg_to_p2 != 3'd0);
                        if (w_round_end) begin
                            r_phase  <= c_GAME_OVER;
                            r_winner <= w_winner_nxt;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        r_phase  <= c_MENU;
                        r_winner <= c_WIN_NONE;
                    end
                end
            endcase
        end
    end

    assign o_phase     = r_phase;
    assign o_freeze    = (r_phase != c_FIGHT);
    assign o_game_over = (r_phase == c_GAME_OVER);
    assign o_p1_health = r_p1_health;
    assign o_p2_health = r_p2_health;
    assign o_timer     = r_timer;
    assign o_countdown = r_countdown;
    assign o_hit_p1    = r_hit_p1;
    assign o_hit_p2    = r_hit_p2;
    assign o_winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_fight_referee.sv
`default_nettype none
// ============================================================================
// Module      : tb_fight_referee
// Description : Directed scoreboard bench for fight_referee.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fight_referee;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_start = 1'b0;
    logic [2:0] i_p1_state = 3'd0;
    logic [2:0] i_p2_state = 3'd0;
    logic [4:0] i_p1_pos = 5'd0;
    logic [4:0] i_p2_pos = 5'd0;
    logic [1:0] o_phase;
    logic       o_freeze;
    logic [2:0] o_p1_health;
    logic [2:0] o_p2_health;
    logic [6:0] o_timer;
    logic [1:0] o_countdown;
    logic       o_hit_p1;
    logic       o_hit_p2;
    logic [1:0] o_winner;
    logic       o_game_over;

    always #10 clk = ~clk;

    fight_referee #(
        .MAX_HEALTH(5), .HIT_RANGE(4), .TICKS_PER_SEC(60),
        .ROUND_SECONDS(60), .COUNTDOWN_SECONDS(3)
    ) dut (
        .clk(clk), .nRst(nRst), .i_tick(i_tick), .i_start(i_start),
        .i_p1_state(i_p1_state), .i_p2_state(i_p2_state),
        .i_p1_pos(i_p1_pos), .i_p2_pos(i_p2_pos),
        .o_phase(o_phase), .o_freeze(o_freeze),
        .o_p1_health(o_p1_health), .o_p2_health(o_p2_health),
        .o_timer(o_timer), .o_countdown(o_countdown),
        .o_hit_p1(o_hit_p1), .o_hit_p2(o_hit_p2),
        .o_winner(o_winner), .o_game_over(o_game_over)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0d required a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic exp_status(input string tag, input int ph, input int h1, input int h2,
                              input int tm, input int cd, input int hit1, input int hit2,
                              input int win);
        push({tag, ".phase"},     32'(ph));
        push({tag, ".p1_health"}, 32'(h1));
        push({tag, ".p2_health"}, 32'(h2));
        push({tag, ".timer"},     32'(tm));
        push({tag, ".countdown"}, 32'(cd));
        push({tag, ".hit_p1"},    32'(hit1));
        push({tag, ".hit_p2"},    32'(hit2));
        push({tag, ".winner"},    32'(win));
        push({tag, ".freeze"},    (ph != 2) ? 32'd1 : 32'd0);
        push({tag, ".game_over"}, (ph == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_status();
        pop_cmp(32'(o_phase));
        pop_cmp(32'(o_p1_health));
        pop_cmp(32'(o_p2_health));
        pop_cmp(32'(o_timer));
        pop_cmp(32'(o_countdown));
        pop_cmp(32'(o_hit_p1));
        pop_cmp(32'(o_hit_p2));
        pop_cmp(32'(o_winner));
        pop_cmp(32'(o_freeze));
        pop_cmp(32'(o_game_over));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    initial begin
        step();
        step();
        exp_status("reset", 0, 5, 5, 60, 0, 0, 0, 0);
        chk_status();
        nRst = 1'b1;

        exp_status("menu_idle", 0, 5, 5, 60, 0, 0, 0, 0);
        tick();
        chk_status();

        // Countdown: 3 seconds of 60 ticks, i_start ignored meanwhile
        exp_status("start", 1, 5, 5, 60, 3, 0, 0, 0);
        pulse_start();
        chk_status();
        ticks(10);
        push("cd_ignores_start", 32'd1);
        pulse_start();
        pop_cmp(32'(o_phase));
        ticks(50);
        push("cd_after_60", 32'd2);
        pop_cmp(32'(o_countdown));
        ticks(60);
        push("cd_after_120", 32'd1);
        pop_cmp(32'(o_countdown));
        ticks(59);
        exp_status("cd_after_179", 1, 5, 5, 60, 1, 0, 0, 0);
        chk_status();
        exp_status("fight_entry", 2, 5, 5, 60, 0, 0, 0, 0);
        tick();
        chk_status();

        // Single jab held for many ticks hits only once
        i_p1_pos = 5'd10;
        i_p2_pos = 5'd13;
        tick();
        i_p1_state = 3'b011;
        exp_status("p1_jab", 2, 5, 4, 60, 0, 0, 1, 0);
        tick();
        chk_status();
        push("jab_pulse_clear", 32'd0);
        step();
        pop_cmp(32'(o_hit_p2));
        ticks(20);
        exp_status("jab_held", 2, 5, 4, 60, 0, 0, 0, 0);
        chk_status();
        i_p1_state = 3'b000;
        tick();

        // Mutual directional attacks at distance 2
        i_p2_pos = 5'd12;
        i_p1_state = 3'b100;
        i_p2_state = 3'b100;
        exp_status("mutual_dir", 2, 3, 2, 60, 0, 1, 1, 0);
        tick();
        chk_status();
        i_p1_state = 3'b000;
        i_p2_state = 3'b000;
        tick();

        // Blocking defender
        i_p2_state = 3'b001;
        i_p1_state = 3'b011;
        exp_status("blocked_jab", 2, 3, 2, 60, 0, 0, 0, 0);
        tick();
        chk_status();
        i_p1_state = 3'b000;
        tick();
        i_p1_state = 3'b100;
        exp_status("blocked_dir", 2, 3, 1, 60, 0, 0, 1, 0);
        tick();
        chk_status();

        // Range boundary, p1 on the right side
        i_p1_state = 3'b000;
        i_p2_state = 3'b000;
        i_p1_pos = 5'd19;
        i_p2_pos = 5'd14;
        tick();
        i_p1_state = 3'b100;
        exp_status("dist5_miss", 2, 3, 1, 60, 0, 0, 0, 0);
        tick();
        chk_status();
        i_p1_state = 3'b000;
        i_p1_pos = 5'd10;
        tick();
        i_p1_state = 3'b100;
        exp_status("dist4_ko", 3, 3, 0, 60, 0, 0, 1, 1);
        tick();
        chk_status();

        // Game over holds against further attacks
        i_p1_state = 3'b000;
        tick();
        i_p1_state = 3'b100;
        tick();
        i_p1_state = 3'b000;
        ticks(5);
        exp_status("go_hold", 3, 3, 0, 60, 0, 0, 0, 1);
        chk_status();
        exp_status("go_to_menu", 0, 3, 0, 60, 0, 0, 0, 0);
        pulse_start();
        chk_status();

        // Full round with no attacks ends in a draw
        exp_status("restart", 1, 5, 5, 60, 3, 0, 0, 0);
        pulse_start();
        chk_status();
        ticks(180);
        push("fight_again", 32'd2);
        pop_cmp(32'(o_phase));
        ticks(59);
        push("timer_59_ticks", 32'd60);
        pop_cmp(32'(o_timer));
        tick();
        push("timer_60_ticks", 32'd59);
        pop_cmp(32'(o_timer));
        ticks(3539);
        exp_status("timer_one_left", 2, 5, 5, 1, 0, 0, 0, 0);
        chk_status();
        exp_status("timeout_draw", 3, 5, 5, 0, 0, 0, 0, 3);
        tick();
        chk_status();

        // Timeout with P1 behind on health
        pulse_start();
        push("menu_again", 32'd0);
        pop_cmp(32'(o_phase));
        pulse_start();
        ticks(180);
        i_p1_pos = 5'd10;
        i_p2_pos = 5'd11;
        i_p2_state = 3'b011;
        exp_status("p2_jab", 2, 4, 5, 60, 0, 1, 0, 0);
        tick();
        chk_status();
        i_p2_state = 3'b000;
        ticks(3598);
        exp_status("timeout_p2_wins", 3, 4, 5, 0, 0, 0, 0, 2);
        tick();
        chk_status();

        // Asynchronous reset mid-fight
        pulse_start();
        pulse_start();
        ticks(180);
        i_p2_state = 3'b100;
        tick();
        i_p2_state = 3'b000;
        tick();
        i_p2_state = 3'b011;
        tick();
        i_p2_state = 3'b000;
        ticks(1797);
        exp_status("pre_reset", 2, 2, 5, 30, 0, 0, 0, 0);
        chk_status();
        #3;
        nRst = 1'b0;
        #2;
        exp_status("async_reset", 0, 5, 5, 60, 0, 0, 0, 0);
        chk_status();
        step();
        nRst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
